// File: rtl/nios_cpu_peripheral_spi_slave.sv
//==============================================================================
// Module   : nios_cpu_peripheral_spi_slave
// Brief    : CPU-mapped SPI responder (CPOL=1, CPHA=1, MSB first) with
//            synchronised pin inputs. Optional EOP compare register enabled
//            by defining SPI_SLAVE_EOP_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module nios_cpu_peripheral_spi_slave #(
  parameter int DATABITS   = 8,
  parameter int SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam int              CW         = $clog2(DATABITS);
  localparam logic [CW-1:0]   c_last_bit = CW'(DATABITS - 1);
  localparam logic [15:0]     c_irq_mask = 16'h07D8;

  logic [SYNC_DEPTH-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                  r_sclk_q, r_ss_q;
  logic                  w_sclk, w_ss, w_mosi;
  logic                  w_ss_fall, w_ss_rise, w_sclk_fall, w_sclk_rise;

  logic                  r_rd_q, r_wr_q, r_rx_clr;
  logic                  w_rd_pulse, w_wr_pulse;
  logic                  w_wr_tx, w_wr_stat, w_wr_ctrl;

  logic                  r_active, r_done, r_tx_primed;
  logic [CW-1:0]         r_bitcnt;
  logic [DATABITS-1:0]   r_shift, r_tx_hold, r_rx_hold;
  logic                  r_roe, r_toe, r_und, r_rrdy;
  logic                  r_miso, r_irq;
  logic [15:0]           r_control, r_rd_data;

  logic                  w_reload, w_tx_accept;
  logic                  w_trdy, w_tmt, w_err, w_eop;
  logic [15:0]           w_status, w_eop_rd, w_rd_mux;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '1;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b1;
      r_ss_q      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_DEPTH-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_DEPTH-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_DEPTH-2:0], MOSI};
      r_sclk_q    <= w_sclk;
      r_ss_q      <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_DEPTH-1];
  assign w_ss        = r_ss_sync[SYNC_DEPTH-1];
  assign w_mosi      = r_mosi_sync[SYNC_DEPTH-1];
  assign w_ss_fall   = r_ss_q & ~w_ss;
  assign w_ss_rise   = ~r_ss_q & w_ss;
  assign w_sclk_fall = r_active & r_sclk_q & ~w_sclk;
  assign w_sclk_rise = r_active & ~r_sclk_q & w_sclk;

  // Strobes fire once per access even if read_n/write_n stay low longer.
  assign w_rd_pulse = spi_select & ~read_n & ~r_rd_q;
  assign w_wr_pulse = spi_select & ~write_n & ~r_wr_q;
  assign w_wr_tx    = w_wr_pulse & (mem_addr == 3'd1);
  assign w_wr_stat  = w_wr_pulse & (mem_addr == 3'd2);
  assign w_wr_ctrl  = w_wr_pulse & (mem_addr == 3'd3);

  // A reload consumes tx_hold in the same cycle a write may refill it.
  assign w_reload    = w_ss_fall | (r_done & r_active & ~w_ss_rise);
  assign w_tx_accept = w_wr_tx & (~r_tx_primed | w_reload);

  assign w_trdy   = ~r_tx_primed;
  assign w_tmt    = ~r_tx_primed & ~r_active;
  assign w_err    = r_roe | r_toe | r_und;
  assign w_status = {5'b0, r_und, w_eop, w_err, r_rrdy, w_trdy, w_tmt,
                     r_toe, r_roe, 3'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_q    <= 1'b0;
      r_wr_q    <= 1'b0;
      r_rx_clr  <= 1'b0;
      r_control <= '0;
      r_rd_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_rd_q   <= spi_select & ~read_n;
      r_wr_q   <= spi_select & ~write_n;
      r_rx_clr <= w_rd_pulse & (mem_addr == 3'd0);
      if (w_wr_ctrl) r_control <= data_from_cpu;
      if (w_rd_pulse) r_rd_data <= w_rd_mux;
      r_irq <= |(w_status & r_control & c_irq_mask);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (mem_addr)
      3'd0:    w_rd_mux = 16'(r_rx_hold);
      3'd2:    w_rd_mux = w_status;
      3'd3:    w_rd_mux = r_control;
      3'd6:    w_rd_mux = w_eop_rd;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_tx_hold   <= '0;
      r_rx_hold   <= '0;
      r_tx_primed <= 1'b0;
      r_miso      <= 1'b1;
      r_roe       <= 1'b0;
      r_toe       <= 1'b0;
      r_und       <= 1'b0;
      r_rrdy      <= 1'b0;
    end else begin
      r_done <= w_sclk_rise & ~w_ss_rise & (r_bitcnt == c_last_bit);
      if (w_ss_fall) begin
        r_active <= 1'b1;
        r_bitcnt <= '0;
      end else if (w_ss_rise) begin
        r_active <= 1'b0;
        r_bitcnt <= '0;
      end else if (w_sclk_rise) begin
        r_shift  <= {r_shift[DATABITS-2:0], w_mosi};
        r_bitcnt <= (r_bitcnt == c_last_bit) ? '0 : r_bitcnt + CW'(1);
      end
      if (w_sclk_fall && !w_ss_rise) r_miso <= r_shift[DATABITS-1];
      if (r_done) r_rx_hold <= r_shift;
      if (w_reload) r_shift <= r_tx_primed ? r_tx_hold : '1;

      if (w_tx_accept) begin
        r_tx_hold   <= data_from_cpu[DATABITS-1:0];
        r_tx_primed <= 1'b1;
      end else if (w_reload) begin
        r_tx_primed <= 1'b0;
      end

      // Flag sets take priority over every clear source.
      r_rrdy <= r_done | (r_rrdy & ~r_rx_clr);
      r_roe  <= (r_done & r_rrdy & ~r_rx_clr) | (r_roe & ~w_wr_stat);
      r_toe  <= (w_wr_tx & ~w_tx_accept) | (r_toe & ~w_wr_stat);
      r_und  <= (w_reload & ~r_tx_primed) | (r_und & ~w_wr_stat);
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic [DATABITS-1:0] r_eop_val;
  logic                r_eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eop_val <= '0;
      r_eop     <= 1'b0;
    end else begin
      if (w_wr_pulse && mem_addr == 3'd6) r_eop_val <= data_from_cpu[DATABITS-1:0];
      r_eop <= (r_done & (r_shift == r_eop_val))
             | (w_wr_tx & (data_from_cpu[DATABITS-1:0] == r_eop_val))
             | (r_eop & ~w_wr_stat);
    end
  end

  assign w_eop    = r_eop;
  assign w_eop_rd = 16'(r_eop_val);
`else
  assign w_eop    = 1'b0;
  assign w_eop_rd = 16'h0000;
`endif

  assign data_to_cpu = r_rd_data;
  assign irq         = r_irq;
  assign MISO        = r_miso;
  assign MISO_oe     = r_active;

endmodule

`default_nettype wire

// File: tb/tb_nios_cpu_peripheral_spi_slave.sv
//==============================================================================
// Module   : tb_nios_cpu_peripheral_spi_slave
// Brief    : Directed vector bench for the SPI responder (8-bit words).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_nios_cpu_peripheral_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n, spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        irq, SCLK, SS_n, MOSI, MISO, MISO_oe;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios_cpu_peripheral_spi_slave #(.DATABITS(8), .SYNC_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .read_n(read_n),
    .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  typedef struct {
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic [15:0] exp_status;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
    @(negedge clk);
  endtask

  // SPI master: 16 clk per SCLK period, MISO captured just before each rising edge.
  task automatic spi_xfer(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
    mi = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mo[nbits-1-i];
      repeat (8) @(negedge clk);
      mi = {mi[14:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd, mi;

    vecs[0] = '{8'hA5, 8'h3C, 16'h00A5, 16'h003C, 16'h05E0};
    vecs[1] = '{8'h5A, 8'hC3, 16'h005A, 16'h00C3, 16'h05E0};
    vecs[2] = '{8'h0F, 8'hF0, 16'h000F, 16'h00F0, 16'h05E0};
    vecs[3] = '{8'hFF, 8'h01, 16'h00FF, 16'h0001, 16'h05E0};
    vecs[4] = '{8'h81, 8'h7E, 16'h0081, 16'h007E, 16'h05E0};

    reset_n = 1'b0; spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
    mem_addr = '0; data_from_cpu = '0; SCLK = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_to_cpu", data_to_cpu, 16'h0000);
    check("reset irq", {15'b0, irq}, 16'h0000);
    check("reset MISO", {15'b0, MISO}, 16'h0001);
    check("reset MISO_oe", {15'b0, MISO_oe}, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    cpu_read(3'd2, rd);
    check("reset status", rd, 16'h0060);

    // Single-word loopback frames; the end-of-word reload finds no data and flags UND.
    for (int v = 0; v < 5; v++) begin
      cpu_write(3'd1, {8'h00, vecs[v].tx});
      spi_xfer({8'h00, vecs[v].mosi}, 8, mi);
      check($sformatf("vec%0d miso", v), mi, vecs[v].exp_miso);
      cpu_read(3'd2, rd);
      check($sformatf("vec%0d status", v), rd, vecs[v].exp_status);
      cpu_read(3'd0, rd);
      check($sformatf("vec%0d rxdata", v), rd, vecs[v].exp_rx);
      cpu_write(3'd2, 16'h0000);
      cpu_read(3'd2, rd);
      check($sformatf("vec%0d status cleared", v), rd, 16'h0060);
    end

    // Two words in one frame without reading: overrun; second tx written mid-frame.
    cpu_write(3'd1, 16'h0044);
    fork
      spi_xfer(16'h1122, 16, mi);
      begin
        repeat (40) @(negedge clk);
        cpu_write(3'd1, 16'h0099);
      end
    join
    check("overrun miso", mi, 16'h4499);
    cpu_read(3'd2, rd);
    check("overrun status", rd, 16'h05E8);
    cpu_read(3'd0, rd);
    check("overrun rxdata", rd, 16'h0022);
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, rd);
    check("overrun cleared", rd, 16'h0060);

    // Underrun at frame start and UND interrupt.
    spi_xfer(16'h0069, 8, mi);
    check("underrun miso", mi, 16'h00FF);
    cpu_read(3'd2, rd);
    check("underrun status", rd, 16'h05E0);
    cpu_read(3'd0, rd);
    check("underrun rxdata", rd, 16'h0069);
    check("irq before enable", {15'b0, irq}, 16'h0000);
    cpu_write(3'd3, 16'h0400);
    check("irq on UND", {15'b0, irq}, 16'h0001);
    cpu_read(3'd3, rd);
    check("control readback", rd, 16'h0400);
    cpu_write(3'd2, 16'h0000);
    check("irq after clear", {15'b0, irq}, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Abort after five bits, then a clean frame.
    cpu_write(3'd1, 16'h0055);
    spi_xfer(16'h001E, 5, mi);
    cpu_read(3'd2, rd);
    check("abort status", rd, 16'h0060);
    cpu_write(3'd1, 16'h003C);
    spi_xfer(16'h0081, 8, mi);
    check("after abort miso", mi, 16'h003C);
    cpu_read(3'd0, rd);
    check("after abort rxdata", rd, 16'h0081);
    cpu_write(3'd2, 16'h0000);

    // Second txdata write while TRDY=0 is dropped and flags TOE.
    cpu_write(3'd1, 16'h00AA);
    cpu_write(3'd1, 16'h00BB);
    cpu_read(3'd2, rd);
    check("toe status primed", rd, 16'h0110);
    spi_xfer(16'h0012, 8, mi);
    check("toe miso", mi, 16'h00AA);
    cpu_read(3'd2, rd);
    check("toe status after frame", rd, 16'h05F0);
    cpu_read(3'd0, rd);
    check("toe rxdata", rd, 16'h0012);
    cpu_write(3'd2, 16'h0000);

`ifdef SPI_SLAVE_EOP_EN
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6, rd);
    check("eop readback", rd, 16'h000D);
    cpu_write(3'd1, 16'h0033);
    spi_xfer(16'h000D, 8, mi);
    cpu_read(3'd2, rd);
    check("eop status", rd, 16'h07E0);
    cpu_write(3'd3, 16'h0200);
    check("eop irq", {15'b0, irq}, 16'h0001);
    cpu_write(3'd3, 16'h0000);
    cpu_write(3'd2, 16'h0000);
`else
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6, rd);
    check("eop reg absent", rd, 16'h0000);
`endif

    // Reset asserted mid-frame.
    cpu_write(3'd1, 16'h0077);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    SCLK = 1'b0;
    MOSI = 1'b1;
    repeat (8) @(negedge clk);
    check("midframe MISO_oe", {15'b0, MISO_oe}, 16'h0001);
    check("midframe MISO bit7", {15'b0, MISO}, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset MISO_oe", {15'b0, MISO_oe}, 16'h0000);
    check("midreset MISO", {15'b0, MISO}, 16'h0001);
    check("midreset irq", {15'b0, irq}, 16'h0000);
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    cpu_read(3'd2, rd);
    check("post-reset status", rd, 16'h0060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
